// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready handshake bundle for the FIFO controller: producer side (in_*)
// and consumer side (out_*). The slave modport is the controller's view.
interface sram_fifo_ctrl_if #(
    parameter int unsigned DataWidth = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DataWidth-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a two-port SRAM bank (sync write, async read) with a
// registered output stage; capacity is the bank depth plus one output word.
module sram_fifo_ctrl #(
    parameter int unsigned DataWidth     = 8,
    parameter int unsigned AddrDepthBits = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sram_fifo_ctrl_if.slave          bus,
    output logic [AddrDepthBits:0]   level_o,
    output logic                     mem_write_enable_o,
    output logic [AddrDepthBits-1:0] mem_write_address_o,
    output logic [DataWidth-1:0]     mem_write_data_o,
    output logic [AddrDepthBits-1:0] mem_read_address_o,
    input  logic [DataWidth-1:0]     mem_read_data_i
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AddrDepthBits:0] wr_ptr_q, wr_ptr_d;
    logic [AddrDepthBits:0] rd_ptr_q, rd_ptr_d;
    logic                   out_valid_q, out_valid_d;
    logic [DataWidth-1:0]   out_data_q, out_data_d;

    logic mem_empty;
    logic mem_full;
    logic push;
    logic load;

    always_comb begin
        mem_empty = (wr_ptr_q == rd_ptr_q);
        mem_full  = (wr_ptr_q[AddrDepthBits] != rd_ptr_q[AddrDepthBits]) &&
                    (wr_ptr_q[AddrDepthBits-1:0] == rd_ptr_q[AddrDepthBits-1:0]);
        push      = bus.in_valid && !mem_full;
        // A load never coincides with a write to the same address: that only
        // happens when the bank is empty, which blocks the load.
        load      = !mem_empty && (!out_valid_q || bus.out_ready);
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_read_data_i;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready        = !mem_full;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign mem_write_enable_o  = push;
    assign mem_write_address_o = wr_ptr_q[AddrDepthBits-1:0];
    assign mem_write_data_o    = bus.in_data;
    assign mem_read_address_o  = rd_ptr_q[AddrDepthBits-1:0];
    assign level_o             = (wr_ptr_q - rd_ptr_q) + {{AddrDepthBits{1'b0}}, out_valid_q};

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives one two-port SRAM bank (sync write, async read). It sits directly around the bank.
- Upstream side: a valid/ready producer whose accepted words become bank writes.
- Downstream side: reads the bank's async port into a registered output stage, giving a valid/ready consumer a glitch-free, registered data output.
- Total capacity is 2**address_depth_bits words in the bank plus 1 word in the output register.

Parameters:
data_width, 8, width of each stored word; must match the attached bank
address_depth_bits, 5, bank address width; bank depth = 2**address_depth_bits

Ports:
clk  input  1  single clock for all logic and the bank write port
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word this cycle
in_data  input  data_width  producer word
out_valid  output  1  out_data holds the head-of-queue word
out_ready  input  1  consumer takes out_data this cycle
out_data  output  data_width  registered head-of-queue word
level  output  address_depth_bits+1  words held, counting bank entries and the output register
mem_write_enable  output  1  to bank write_enable
mem_write_address  output  address_depth_bits  to bank write_address
mem_write_data  output  data_width  to bank write_data
mem_read_address  output  address_depth_bits  to bank read_address
mem_read_data  input  data_width  from bank read_data (async)

Behaviour:
- Reset (rst_n low, async): wr_ptr = 0, rd_ptr = 0, out_valid = 0, out_data = 0, level = 0. Bank contents are not cleared, and all queued data is discarded. If reset is asserted mid-transfer, no write or load occurs on that edge. After release, the next edge operates normally.
- Pointers: wr_ptr and rd_ptr are address_depth_bits+1 bits wide. The MSB is the wrap bit, and the low bits address the bank.
- mem_empty is true when wr_ptr == rd_ptr.
- mem_full is true when the MSBs differ and the low bits are equal.
- in_ready = !mem_full. It is combinational from registered pointers only and has no dependency on in_valid or out_ready.
- push = in_valid && in_ready.
  - mem_write_enable = push, mem_write_address = wr_ptr low bits, mem_write_data = in_data (all combinational).
  - wr_ptr increments on the push edge.
  - in_valid while full is ignored: no write and no pointer change.
- mem_read_address = rd_ptr low bits at all times.
- load = !mem_empty && (!out_valid || out_ready).
  - On a load edge: out_data <= mem_read_data, out_valid <= 1, rd_ptr increments.
- Pop-only (out_valid && out_ready && mem_empty): out_valid <= 0 and out_data holds its old value.
- Hold: while out_valid && !out_ready, out_data and out_valid are stable.
- First-word latency: a word pushed on edge N is written to the bank at edge N. The bank is non-empty in cycle N+1, the load occurs at edge N+1, and out_valid is high from cycle N+2.
- Streaming: with continuous push and out_ready=1, one word per cycle flows in each direction.
- Read/write hazard: the same address is read and written in one cycle only when mem_empty, and then no load occurs. The bank's read-during-write behaviour is therefore never relied on.
- Simultaneous push and load are both legal in the same cycle, and both pointers advance.
- Wrap-around: pointers wrap naturally modulo 2**(address_depth_bits+1). Order is preserved across the wrap.
- level = (wr_ptr - rd_ptr) modulo 2**(address_depth_bits+1), plus out_valid. It is registered-path combinational, with maximum 2**address_depth_bits + 1.
- Ordering: strict FIFO with no loss or duplication.

Test Plan:
- Reset, then push 0x11 in one cycle with out_ready=0 -> mem_write_enable pulses with address 0. out_valid rises 2 cycles later with out_data=0x11, and level = 1.
- Push 0x00..0x20 (33 words) with out_ready=0 -> in_ready drops after the 33rd accept and level = 33. A 34th in_valid is ignored and the bank is not written.
- From full, set out_ready=1 while in_valid=1 streams 0x40.. -> output sequence 0x00..0x20 then 0x40.., in_ready recovers one cycle after the first pop, and there are no gaps in out_valid.
- Stall: out_ready=0 for 5 cycles while out_valid=1 -> out_data and level are unchanged. Release -> the next word appears on the following cycle.
- Wrap: 100 random pushes/pops at about 50% duty, checked against a reference queue -> identical order, level always matches, and the pointers wrap at least twice.
- Assert rst_n low mid-stream with the queue holding 10 words -> out_valid=0, level=0, in_ready=1 immediately. The next pushed word (0x5A) is the first word out.
